// File: rtl/result_uart_pkg.sv
// Shared types and constants for the result UART transmitter.
package result_uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic LINE_IDLE      = 1'b1;
    localparam logic LINE_START     = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO for buffered ALU results; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wr_data,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers 8-bit ALU results and serialises them LSB first as UART 8N1.
// Define RESULT_UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module result_uart_tx
    import result_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int DW           = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        res_valid,
    input  logic [DW-1:0]               res_data,
    input  logic                        ovf_clr,
    output logic                        tx,
    output logic                        busy,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                BIT_W     = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DW-1:0]     shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              pop, baud_end, fifo_empty;
    logic [DW-1:0]     fifo_rd_data;

    result_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (res_valid),
        .pop     (pop),
        .wr_data (res_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        baud_d  = (state_q == ST_IDLE || baud_end) ? '0 : baud_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    par_d   = ^fifo_rd_data;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef RESULT_UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Reload straight from the FIFO so consecutive frames abut with no idle gap.
                if (baud_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        par_d   = ^fifo_rd_data;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line level is computed from the next state so tx is a clean register output.
    always_comb begin
        tx_d   = LINE_IDLE;
        busy_d = (state_d != ST_IDLE);
        ovf_d  = ovf_q;
        case (state_d)
            ST_START:  tx_d = LINE_START;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = LINE_IDLE;
        endcase
        if (res_valid && fifo_full && !pop) ovf_d = 1'b1;
        else if (ovf_clr)                   ovf_d = 1'b0;
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule
